hartslag_detector: RTL and testbench

Conditions the raw heartbeat sensor line into clean, single-cycle beat pulses for the heart-rhythm interval measurer that sits directly downstream. It synchronizes the asynchronous sensor input, rejects glitches with a stable-high qualification window and suppresses double-counting with a refractory lockout. It also counts beats and raises a no-beat alarm when no valid beat arrives within a timeout. Its `slag` output drives the downstream block's `ingang` input.

---
 rtl/hartslag_detector.sv | 108 ++++++++++
 tb/tb_hartslag_detector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hartslag_detector.sv
// Heartbeat sensor conditioner: synchronizes the raw sensor line, qualifies beats with a
// stable-high window, applies a refractory lockout, counts beats and flags missing beats.
module hartslag_detector #(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned REFRACTORY_CYCLES = 12500000,
  parameter int unsigned TIMEOUT_CYCLES    = 150000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       enable,
  output logic       slag,
  output logic [7:0] aantal,
  output logic       geenSlag,
  output logic [1:0] toestand
);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    QUALIFY  = 2'd1,
    LOCKOUT  = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  localparam logic [27:0] DEB_LAST = 28'(DEBOUNCE_CYCLES - 1);
  localparam logic [27:0] REF_LAST = 28'(REFRACTORY_CYCLES - 1);
  localparam logic [27:0] TMO      = 28'(TIMEOUT_CYCLES);

  state_t      state;
  logic        s1;
  logic        s2;
  logic [27:0] cnt;
  logic [27:0] tc;
  logic [27:0] tc_sat;
  logic        fire;

  assign toestand = state;

  // A beat is issued on the edge where the qualification window completes.
  assign fire   = (state == QUALIFY) && s2 && (cnt == DEB_LAST);
  assign tc_sat = (tc == TMO) ? tc : tc + 28'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= ARMED;
      cnt      <= '0;
      tc       <= '0;
      slag     <= 1'b0;
      aantal   <= '0;
      geenSlag <= 1'b0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
      if (!enable) begin
        state    <= ARMED;
        cnt      <= '0;
        tc       <= '0;
        slag     <= 1'b0;
        geenSlag <= 1'b0;
      end else begin
        slag <= fire;
        if (fire) begin
          aantal   <= aantal + 8'd1;
          tc       <= '0;
          geenSlag <= 1'b0;
        end else begin
          tc       <= tc_sat;
          geenSlag <= (tc_sat == TMO);
        end

        case (state)
          ARMED: begin
            if (s2) begin
              state <= QUALIFY;
              cnt   <= '0;
            end
          end
          QUALIFY: begin
            if (!s2) begin
              state <= ARMED;
            end else if (cnt == DEB_LAST) begin
              state <= LOCKOUT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 28'd1;
            end
          end
          LOCKOUT: begin
            if (cnt == REF_LAST) begin
              state <= WAIT_LOW;
            end else begin
              cnt <= cnt + 28'd1;
            end
          end
          WAIT_LOW: begin
            if (!s2) begin
              state <= ARMED;
            end
          end
          default: state <= ARMED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hartslag_detector.sv
// Directed bench for hartslag_detector with small parameters; expected beats are queued
// when stimulus is driven and matched (edge number and count) when slag appears.
module tb_hartslag_detector;

  localparam int D = 4;
  localparam int R = 10;
  localparam int T = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor;
  logic       enable;
  logic       slag;
  logic [7:0] aantal;
  logic       geenSlag;
  logic [1:0] toestand;

  typedef struct {
    int         e;
    logic [7:0] a;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         edge_n   = 0;
  int         pulses   = 0;
  logic [7:0] exp_cnt  = '0;

  hartslag_detector #(
    .DEBOUNCE_CYCLES  (D),
    .REFRACTORY_CYCLES(R),
    .TIMEOUT_CYCLES   (T)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sensor  (sensor),
    .enable  (enable),
    .slag    (slag),
    .aantal  (aantal),
    .geenSlag(geenSlag),
    .toestand(toestand)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the rising edge, and score any slag pulse.
  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    edge_n++;
    if (slag === 1'b1) begin
      pulses++;
      if (sb.size() > 0) begin
        x = sb.pop_front();
      end else begin
        x.e = -1;
        x.a = '0;
      end
      check("slag_edge", edge_n, x.e);
      check("slag_aantal", {24'b0, aantal}, {24'b0, x.a});
    end
  endtask

  task automatic idle(input int n);
    sensor = 1'b0;
    repeat (n) tick();
  endtask

  // Sensor rises now, so the next edge is E0; the pulse is expected after E(D+2).
  task automatic expect_beat();
    exp_t x;
    exp_cnt = exp_cnt + 8'd1;
    x.e = edge_n + 1 + D + 2;
    x.a = exp_cnt;
    sb.push_back(x);
  endtask

  task automatic beat(input int high);
    sensor = 1'b1;
    expect_beat();
    repeat (high) tick();
    sensor = 1'b0;
  endtask

  task automatic sb_done(input string tag);
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    sensor = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    check("rst_slag", slag, 0);
    check("rst_aantal", aantal, 0);
    check("rst_geenslag", geenSlag, 0);
    check("rst_toestand", toestand, 0);
    reset = 1'b0;

    // Clean beat with the state sequence
    idle(2);
    sensor = 1'b1;
    expect_beat();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 1)  check("clean_st_e1", toestand, 0);
      if (i == 2)  check("clean_st_e2", toestand, 1);
      if (i == 5)  check("clean_st_e5", toestand, 1);
      if (i == 6)  check("clean_st_e6", toestand, 2);
      if (i == 15) check("clean_st_e15", toestand, 2);
      if (i == 16) check("clean_st_e16", toestand, 3);
      if (i == 19) check("clean_st_e19", toestand, 3);
    end
    sensor = 1'b0;
    repeat (3) tick();
    check("clean_st_armed", toestand, 0);
    check("clean_aantal", aantal, 1);
    sb_done("clean_pending");

    // Glitch: four sampled highs never qualify
    idle(5);
    sensor = 1'b1;
    repeat (4) tick();
    check("glitch_qualify", toestand, 1);
    idle(10);
    check("glitch_armed", toestand, 0);
    check("glitch_aantal", aantal, 1);
    sb_done("glitch_pending");

    // Five sampled highs is the shortest pulse that qualifies
    beat(5);
    idle(20);
    check("min_aantal", aantal, 2);
    sb_done("min_pending");

    // Bouncing sensor during lockout
    sensor = 1'b1;
    expect_beat();
    repeat (7) tick();
    for (int i = 0; i < 10; i++) begin
      sensor = (i % 2 == 0);
      tick();
      if (i == 5) check("bounce_lockout", toestand, 2);
    end
    idle(20);
    check("bounce_aantal", aantal, 3);
    sb_done("bounce_pending");

    // enable dropped mid-QUALIFY
    sensor = 1'b1;
    repeat (4) tick();
    check("abort_qualify", toestand, 1);
    enable = 1'b0;
    tick();
    check("abort_armed", toestand, 0);
    check("abort_slag", slag, 0);
    repeat (3) tick();
    idle(3);
    enable = 1'b1;
    idle(5);
    check("abort_aantal", aantal, 3);
    sb_done("abort_pending");

    // enable dropped on the very edge a pulse would issue
    sensor = 1'b1;
    repeat (6) tick();
    check("enfall_qualify", toestand, 1);
    enable = 1'b0;
    tick();
    check("enfall_slag", slag, 0);
    check("enfall_aantal", aantal, 3);
    check("enfall_geenslag", geenSlag, 0);
    idle(3);
    enable = 1'b1;
    idle(3);
    sb_done("enfall_pending");

    // Asynchronous reset while in LOCKOUT
    sensor = 1'b1;
    expect_beat();
    repeat (7) tick();
    check("rstlock_lockout", toestand, 2);
    check("rstlock_slag_before", slag, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rstlock_slag", slag, 0);
    check("rstlock_aantal", aantal, 0);
    check("rstlock_toestand", toestand, 0);
    check("rstlock_geenslag", geenSlag, 0);
    sensor  = 1'b0;
    exp_cnt = '0;
    sb_done("rstlock_pending");
    tick();
    reset = 1'b0;

    // Timeout after reset, then a beat clears it and the count restarts
    repeat (49) tick();
    check("tmo_49", geenSlag, 0);
    tick();
    check("tmo_50", geenSlag, 1);
    repeat (5) tick();
    check("tmo_55", geenSlag, 1);
    sensor = 1'b1;
    expect_beat();
    repeat (6) tick();
    check("tmo_before_beat", geenSlag, 1);
    tick();
    check("tmo_beat_slag", slag, 1);
    check("tmo_beat_clear", geenSlag, 0);
    sensor = 1'b0;
    repeat (49) tick();
    check("tmo_restart_49", geenSlag, 0);
    tick();
    check("tmo_restart_50", geenSlag, 1);
    check("tmo_aantal", aantal, 1);
    sb_done("tmo_pending");

    // Pulse coincides with the timeout edge: the pulse wins
    #2;
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    exp_cnt = '0;
    repeat (43) tick();
    sensor = 1'b1;
    expect_beat();
    repeat (6) tick();
    check("simul_49", geenSlag, 0);
    tick();
    check("simul_slag", slag, 1);
    check("simul_geenslag", geenSlag, 0);
    sensor = 1'b0;
    repeat (49) tick();
    check("simul_after_49", geenSlag, 0);
    tick();
    check("simul_after_50", geenSlag, 1);
    sb_done("simul_pending");

    // 256 beats wrap the counter
    #2;
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    exp_cnt = '0;
    pulses  = 0;
    for (int b = 0; b < 256; b++) begin
      beat(5);
      idle(15);
      if (b == 254) check("wrap_255", aantal, 255);
    end
    check("wrap_0", aantal, 0);
    check("wrap_pulses", pulses, 256);
    sb_done("wrap_pending");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
